memory_port_arbiter: RTL and testbench

// Shares the core's single memory port between NUM_REQ requesters (req 0 = instruction fetcher,
// req 1 = executor load/store). Round-robin grant, one outstanding transaction at a time,
// per-transaction timeout. Sits between fetcher/executor and the memory/IO bus; core sequencing unchanged.

---
 rtl/mem_bus_pkg.sv | 14 +
 rtl/memory_port_arbiter_picker.sv | 27 ++
 rtl/memory_port_arbiter.sv | 121 ++++++++++++
 tb/tb_memory_port_arbiter.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_pkg.sv
// Shared types and width defaults for the core's memory-bus blocks.
// Arbiter states and default address/data widths live here so every bus client agrees on them.
package mem_bus_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ISSUE,
    ARB_DONE
  } arb_state_t;

  localparam int MEM_ADDR_W = 32;
  localparam int MEM_DATA_W = 32;

endpackage

// File: rtl/memory_port_arbiter_picker.sv
// Combinational round-robin picker: first asserted request scanning from last_grant+1 upward,
// wrapping modulo NUM_REQ, so the most recently served requester has lowest priority.
module round_robin_picker #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   last_grant_i,
  output logic               any_o,
  output logic [IDX_W-1:0]   winner_o
);

  always_comb begin
    logic [IDX_W-1:0] idx;
    any_o    = 1'b0;
    winner_o = '0;
    idx      = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = IDX_W'((int'(last_grant_i) + i) % NUM_REQ);
      if (!any_o && req_i[idx]) begin
        any_o    = 1'b1;
        winner_o = idx;
      end
    end
  end

endmodule

// File: rtl/memory_port_arbiter.sv
// Shares the single memory port between NUM_REQ requesters: round-robin grant, one transaction
// in flight, per-transaction timeout. All outputs registered; IDLE -> ISSUE -> DONE -> IDLE.
module memory_port_arbiter
  import mem_bus_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = MEM_ADDR_W,
  parameter int DATA_W  = MEM_DATA_W,
  parameter int TIMEOUT = 255
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ-1:0]             req_we,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ-1:0][DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]             ack,
  output logic                           err,
  output logic [DATA_W-1:0]              rdata,
  output logic                           mem_req,
  output logic                           mem_we,
  output logic [ADDR_W-1:0]              mem_addr,
  output logic [DATA_W-1:0]              mem_wdata,
  input  logic                           mem_ack,
  input  logic [DATA_W-1:0]              mem_rdata
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  arb_state_t          state_q;
  logic [IDX_W-1:0]    last_grant_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [NUM_REQ-1:0]  ack_q;
  logic                err_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                mem_req_q;
  logic                mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;

  logic                pick_any;
  logic [IDX_W-1:0]    pick_idx;

  round_robin_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req_i        (req),
    .last_grant_i (last_grant_q),
    .any_o        (pick_any),
    .winner_o     (pick_idx)
  );

  // last_grant_q doubles as the owner of the in-flight transaction.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ARB_IDLE;
      last_grant_q <= IDX_W'(NUM_REQ - 1);
      cnt_q        <= '0;
      ack_q        <= '0;
      err_q        <= 1'b0;
      rdata_q      <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          mem_req_q <= 1'b0;
          if (pick_any) begin
            mem_req_q    <= 1'b1;
            mem_we_q     <= req_we[pick_idx];
            mem_addr_q   <= req_addr[pick_idx];
            mem_wdata_q  <= req_wdata[pick_idx];
            last_grant_q <= pick_idx;
            cnt_q        <= '0;
            state_q      <= ARB_ISSUE;
          end
        end
        ARB_ISSUE: begin
          // A real completion takes precedence over a timeout in the same cycle.
          if (mem_ack) begin
            rdata_q   <= mem_rdata;
            mem_req_q <= 1'b0;
            ack_q     <= NUM_REQ'(1) << last_grant_q;
            err_q     <= 1'b0;
            state_q   <= ARB_DONE;
          end else if (cnt_q == CNT_LAST) begin
            rdata_q   <= '0;
            mem_req_q <= 1'b0;
            ack_q     <= NUM_REQ'(1) << last_grant_q;
            err_q     <= 1'b1;
            state_q   <= ARB_DONE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ARB_DONE: begin
          ack_q   <= '0;
          err_q   <= 1'b0;
          state_q <= ARB_IDLE;
        end
        default: begin
          state_q <= ARB_IDLE;
        end
      endcase
    end
  end

  assign ack       = ack_q;
  assign err       = err_q;
  assign rdata     = rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Directed and randomized checks of memory_port_arbiter against a transaction-level model.
module tb_memory_port_arbiter;

  localparam int NR = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [NR-1:0]          req;
  logic [NR-1:0]          req_we;
  logic [NR-1:0][AW-1:0]  req_addr;
  logic [NR-1:0][DW-1:0]  req_wdata;
  logic [NR-1:0]          ack;
  logic                   err;
  logic [DW-1:0]          rdata;
  logic                   mem_req;
  logic                   mem_we;
  logic [AW-1:0]          mem_addr;
  logic [DW-1:0]          mem_wdata;
  logic                   mem_ack;
  logic [DW-1:0]          mem_rdata;

  int n_chk = 0;
  int n_fail = 0;
  int last_m;
  logic [DW-1:0] rdata_m;

  always #5 clk = ~clk;

  memory_port_arbiter #(
    .NUM_REQ (NR),
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .TIMEOUT (TO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .ack       (ack),
    .err       (err),
    .rdata     (rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Round robin as stated: first set bit scanning last+1, last+2, ... modulo NR.
  function automatic int rr(input int last, input logic [NR-1:0] r);
    for (int o = 1; o <= NR; o++) begin
      int k;
      k = (last + o) % NR;
      if (r[k]) return k;
    end
    return -1;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset   = 1'b0;
    last_m  = NR - 1;
    rdata_m = '0;
  endtask

  // Called in an IDLE cycle; leaves the bench in the following IDLE cycle.
  // d = ISSUE cycle in which memory acks (d >= TO means never).
  task automatic txn(input logic [NR-1:0] rq, input int d, input logic keep, input logic [DW-1:0] rd);
    int w;
    logic timed_out;
    logic [AW-1:0] ea;
    logic ewe;
    logic [DW-1:0] ewd;
    req = rq;
    w = rr(last_m, rq);
    last_m = w;
    ea  = req_addr[w];
    ewe = req_we[w];
    ewd = req_wdata[w];
    timed_out = (d >= TO);
    step();
    for (int j = 0; j < TO; j++) begin
      chk($sformatf("issue%0d_mem_req", j), 64'(mem_req), 64'd1);
      chk($sformatf("issue%0d_mem_addr", j), 64'(mem_addr), 64'(ea));
      chk($sformatf("issue%0d_mem_we", j), 64'(mem_we), 64'(ewe));
      chk($sformatf("issue%0d_mem_wdata", j), 64'(mem_wdata), 64'(ewd));
      chk($sformatf("issue%0d_ack", j), 64'(ack), 64'd0);
      if (j == d) begin
        mem_ack   = 1'b1;
        mem_rdata = rd;
      end
      step();
      mem_ack   = 1'b0;
      mem_rdata = $urandom;
      if (j == d) break;
    end
    rdata_m = timed_out ? '0 : rd;
    chk("done_ack", 64'(ack), 64'd1 << w);
    chk("done_err", 64'(err), 64'(timed_out));
    chk("done_rdata", 64'(rdata), 64'(rdata_m));
    chk("done_mem_req", 64'(mem_req), 64'd0);
    if (!keep) req[w] = 1'b0;
    step();
    chk("idle_ack", 64'(ack), 64'd0);
    chk("idle_err", 64'(err), 64'd0);
    chk("idle_mem_req", 64'(mem_req), 64'd0);
    chk("idle_rdata_held", 64'(rdata), 64'(rdata_m));
  endtask

  initial begin
    logic [NR-1:0] nxt;
    reset     = 1'b1;
    req       = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
    mem_ack   = 1'b0;
    mem_rdata = '0;

    do_reset();
    reset = 1'b1;
    chk("rst_ack", 64'(ack), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_rdata", 64'(rdata), 64'd0);
    chk("rst_mem_req", 64'(mem_req), 64'd0);
    chk("rst_mem_we", 64'(mem_we), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    reset = 1'b0;

    // Single read from req0, memory acks in the 4th ISSUE cycle (coincides with the timeout cycle).
    req_addr[0] = 32'h0000_1000;
    req_we[0]   = 1'b0;
    txn(2'b01, 3, 1'b0, 32'hDEAD_BEEF);

    // Write from req1.
    req_addr[1]  = 32'h0000_0100;
    req_wdata[1] = 32'h1234_5678;
    req_we[1]    = 1'b1;
    txn(2'b10, 2, 1'b0, 32'hCAFE_0001);

    // Timeout: memory never answers.
    txn(2'b01, 99, 1'b0, 32'h5555_AAAA);

    // Both requesters continuously active from reset: grants alternate 0,1,0,1.
    do_reset();
    req_addr[0] = 32'h0000_00A0;
    req_addr[1] = 32'h0000_00B0;
    req_we      = '0;
    for (int i = 0; i < 4; i++) txn(2'b11, 0, 1'b1, DW'(32'h1000 + i));

    // Reset during ISSUE aborts with no ack; stray mem_ack in IDLE is ignored.
    req = 2'b10;
    step();
    chk("pre_reset_mem_req", 64'(mem_req), 64'd1);
    reset = 1'b1;
    step();
    chk("abort_mem_req", 64'(mem_req), 64'd0);
    chk("abort_ack", 64'(ack), 64'd0);
    chk("abort_rdata", 64'(rdata), 64'd0);
    reset   = 1'b0;
    last_m  = NR - 1;
    rdata_m = '0;
    req     = '0;
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    chk("stray_ack", 64'(ack), 64'd0);
    chk("stray_mem_req", 64'(mem_req), 64'd0);
    step();
    chk("stray_ack_late", 64'(ack), 64'd0);
    txn(2'b11, 1, 1'b0, 32'h0BAD_F00D);

    // Randomized traffic: unserved requests stay held with stable attributes.
    for (int it = 0; it < 80; it++) begin
      for (int i = 0; i < NR; i++) begin
        if (req[i]) begin
          nxt[i] = 1'b1;
        end else begin
          nxt[i]       = 1'($urandom_range(0, 1));
          req_we[i]    = 1'($urandom_range(0, 1));
          req_addr[i]  = $urandom;
          req_wdata[i] = $urandom;
        end
      end
      if (nxt == '0) begin
        mem_ack = 1'($urandom_range(0, 1));
        step();
        mem_ack = 1'b0;
        chk("rnd_idle_mem_req", 64'(mem_req), 64'd0);
        chk("rnd_idle_ack", 64'(ack), 64'd0);
      end else begin
        txn(nxt, $urandom_range(0, 5), 1'b0, $urandom);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
